// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiply, restoring divide,
// optional RV64 word ops, valid/ready on both sides and a pipeline kill.
module muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 4,
    parameter int unsigned EN_WORD  = 0,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned AW    = XLEN + MUL_BITS;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [2:0]       state, state_d;
    logic [2:0]       op_q;
    logic             word_q, neg_a, neg_b, spec_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_reg, b_reg;
    logic [PW-1:0]    p_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept, word_in, is_div, s1, s2, neg1, neg2;
    logic             div_zero, ovf, special;
    logic [2:0]       f3_eff;
    logic [XLEN-1:0]  ext1, ext2, mag1, mag2, rs1_res, min_w, spec_res, aligned;
    logic [CNT_W-1:0] cnt_init;

    logic [AW-1:0]    sum;
    logic [PW-1:0]    mul_next, div_next, prod, prod_s;
    logic [XLEN:0]    rem_sh, diff;
    logic [XLEN-1:0]  quo_s, rem_s, pick, fix_res;

    assign in_ready = (state == ST_IDLE) && !kill;
    assign accept   = in_valid && in_ready;
    assign word_in  = (EN_WORD != 0) && in_word;

    // Operand decode: effective op, sign flags, magnitudes and early-out results
    always_comb begin
        f3_eff   = (word_in && !in_funct3[2]) ? 3'b000 : in_funct3;
        is_div   = f3_eff[2];
        s1       = is_div ? !f3_eff[0] : (f3_eff[1:0] != 2'b11);
        s2       = is_div ? !f3_eff[0] : !f3_eff[1];
        ext1     = word_in ? (s1 ? sx32(in_rs1[31:0]) : XLEN'(in_rs1[31:0])) : in_rs1;
        ext2     = word_in ? (s2 ? sx32(in_rs2[31:0]) : XLEN'(in_rs2[31:0])) : in_rs2;
        neg1     = s1 && ext1[XLEN-1];
        neg2     = s2 && ext2[XLEN-1];
        mag1     = neg1 ? -ext1 : ext1;
        mag2     = neg2 ? -ext2 : ext2;
        rs1_res  = word_in ? sx32(in_rs1[31:0]) : in_rs1;
        min_w    = word_in ? sx32(32'h8000_0000) : MIN_X;
        div_zero = (ext2 == '0);
        ovf      = s1 && (ext1 == min_w) && (ext2 == '1);
        special  = is_div && (div_zero || ovf);
        if (div_zero) spec_res = f3_eff[1] ? rs1_res : '1;
        else          spec_res = f3_eff[1] ? '0 : rs1_res;
        aligned  = word_in ? (mag1 << (XLEN - 32)) : mag1;
        if (is_div) cnt_init = word_in ? CNT_W'(31) : CNT_W'(XLEN - 1);
        else        cnt_init = word_in ? CNT_W'(32 / MUL_BITS - 1) : CNT_W'(XLEN / MUL_BITS - 1);
    end

    // One multiply step (MUL_BITS multiplier bits) and one restoring divide step
    always_comb begin
        sum      = {{MUL_BITS{1'b0}}, p_reg[PW-1:XLEN]}
                 + AW'(a_reg) * AW'(p_reg[MUL_BITS-1:0]);
        mul_next = PW'({sum, p_reg[XLEN-1:0]} >> MUL_BITS);
        rem_sh   = {p_reg[PW-1:XLEN], p_reg[XLEN-1]};
        diff     = rem_sh - {1'b0, b_reg};
        div_next = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]),
                    p_reg[XLEN-2:0], ~diff[XLEN]};
    end

    // Sign fix-up and result selection
    always_comb begin
        prod   = word_q ? (p_reg >> (XLEN - 32)) : p_reg;
        prod_s = (neg_a ^ neg_b) ? -prod : prod;
        quo_s  = (neg_a ^ neg_b) ? -p_reg[XLEN-1:0] : p_reg[XLEN-1:0];
        rem_s  = neg_a ? -p_reg[PW-1:XLEN] : p_reg[PW-1:XLEN];
        pick   = op_q[1] ? rem_s : quo_s;
        if (spec_q)
            fix_res = p_reg[XLEN-1:0];
        else if (!op_q[2])
            fix_res = word_q ? sx32(prod_s[31:0])
                    : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN]);
        else
            fix_res = word_q ? sx32(pick[31:0]) : pick;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) state_d = special ? ST_FIX : (is_div ? ST_DIV : ST_MUL);
                ST_MUL:  if (cnt == '0) state_d = ST_FIX;
                ST_DIV:  if (cnt == '0) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Datapath: capture at accept, then iterate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            word_q <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            spec_q <= 1'b0;
            tag_q  <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            p_reg  <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= f3_eff;
            word_q <= word_in;
            neg_a  <= neg1;
            neg_b  <= neg2;
            spec_q <= special;
            tag_q  <= in_tag;
            a_reg  <= mag1;
            b_reg  <= mag2;
            cnt    <= cnt_init;
            if (special)     p_reg <= {{XLEN{1'b0}}, spec_res};
            else if (is_div) p_reg <= {{XLEN{1'b0}}, aligned};
            else             p_reg <= {{XLEN{1'b0}}, mag2};
        end else if (state == ST_MUL) begin
            p_reg <= mul_next;
            cnt   <= cnt - CNT_W'(1);
        end else if (state == ST_DIV) begin
            p_reg <= div_next;
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Result port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            out_valid <= (state_d == ST_DONE);
            if (state == ST_FIX && !kill) begin
                out_result <= fix_res;
                out_tag    <= tag_q;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RISC-V M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, selected by funct3 per the team's M-extension funct3 encoding.
- Parametrised in XLEN and multiply radix; optionally supports the RV64 *W word ops (OP_32 opcode group).
- Sits beside the integer ALU in execute, with valid/ready handshakes on both sides and a kill input for pipeline flush.

Parameters:
XLEN, 32, datapath width; 32 or 64.
MUL_BITS, 4, multiplier bits retired per cycle; must divide 32.
EN_WORD, 0, 1 = honour in_word (*W ops); legal only with XLEN=64.
TAG_W, 5, width of destination tag carried through.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
kill  in  1  abort the current operation.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept; high only in IDLE with kill=0.
in_funct3  in  3  M-extension funct3.
in_word  in  1  *W op; ignored when EN_WORD=0.
in_rs1  in  XLEN  operand 1 (multiplicand/dividend).
in_rs2  in  XLEN  operand 2 (multiplier/divisor).
in_tag  in  TAG_W  destination tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_result  out  XLEN  result.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE. Reset (async) forces IDLE, out_valid=0, out_result=0, out_tag=0, all internal registers 0. in_ready=1 after reset release.
- Accept occurs when in_valid && in_ready at a rising edge (E0). Operands, funct3, word and tag are registered at E0.
- Word mode (EN_WORD=1 and in_word=1):
  - Operate on rs1[31:0] and rs2[31:0]; effective width W=32.
  - Final result is the 32-bit result sign-extended to XLEN.
  - funct3 001..011 with in_word is treated as MULW.
- Otherwise W=XLEN.
- MUL path:
  - Operands are taken as magnitudes plus sign flags per funct3: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Shift-add over MUL_BITS multiplier bits per cycle, W/MUL_BITS cycles in MUL, then 1 cycle in FIX (negate the 2W product if the signs differ).
  - MUL returns product[W-1:0]; MULH, MULHSU and MULHU return product[2W-1:W].
- DIV path:
  - Restoring radix-2 on magnitudes: W cycles in DIV, then FIX.
  - FIX sets quotient negative iff signed op and operand signs differ; remainder takes the sign of the dividend.
- Special cases are decided at E0 and bypass MUL/DIV (go straight to DONE, out_valid at E0+1):
  - Divisor = 0: DIV/DIVU return all ones (W bits, then extended); REM/REMU return the dividend.
  - Signed overflow (dividend = -2^(W-1), divisor = -1): DIV returns the dividend; REM returns 0.
- Latency (accept edge E0 to first edge where out_valid=1):
  - MUL: E0+W/MUL_BITS+1.
  - DIV: E0+W+1.
  - Special cases: E0+1.
- DONE: out_valid=1. out_result and out_tag are held stable until out_valid && out_ready, then IDLE on that edge. in_ready is low in DONE, so back-to-back issue has a minimum 1-cycle gap.
- kill=1 in any state: IDLE at the next edge, out_valid=0, result discarded. With kill=1 in IDLE, in_ready=0, so nothing is accepted.
- out_ready may be high before out_valid; that has no effect.
- Changes on in_* after E0 do not affect an in-flight operation.

Test Plan:
- XLEN=32, MUL_BITS=4: MUL rs1=7, rs2=0xFFFFFFFD -> out_result=0xFFFFFFEB at E0+9; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at E0+33; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at E0+1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> result and tag stable, in_ready=0; the unit returns to IDLE on the edge where out_ready=1; the next accept happens one cycle later.
- Kill mid-DIV (cycle 10 after E0) -> out_valid never asserts; in_ready=1 the cycle after. Assert rst mid-MUL -> out_valid and out_result drop to 0 immediately (asynchronously).
- XLEN=64, EN_WORD=1: DIVW rs1=0x00000000_80000000, rs2=0xFFFFFFFF_FFFFFFFF -> 0xFFFFFFFF_80000000 at E0+1; MULW 0x1_00000003×2 -> 0x00000000_00000006 at E0+9; 64-bit MUL latency is E0+17.
